// File: rtl/truth_table_sweeper.sv
// truth_table_sweeper
//   Exhaustively sweeps every N_IN-bit input vector (binary or Gray order)
//   into a small combinational unit under test. Each vector is held for
//   SETTLE cycles, the 1-bit response is sampled on the last of those cycles,
//   and it is compared against a truth table latched at start.
//
// Ports
//   clk              in   clock, rising edge active
//   rst              in   asynchronous active-high reset
//   start            in   begins a sweep (honoured in IDLE or DONE only)
//   expected         in   [2**N_IN] expected truth table, bit k = response to vector k
//   dut_out          in   response of the unit under test
//   stim             out  [N_IN] vector currently applied
//   busy             out  sweep in progress
//   done             out  sweep finished, results valid
//   pass             out  1 iff the last sweep had no mismatches (valid with done)
//   err_count        out  [N_IN+1] mismatching vectors in the current/last sweep
//   first_err_valid  out  at least one mismatch seen
//   first_err_vec    out  [N_IN] stim value of the first mismatch
//   captured         out  [2**N_IN] observed truth table, bit k = response to vector k
//   fsm_state        out  [2] debug view of the control state (0 IDLE, 1 RUN, 2 DONE)
//
// Handshake: start is a level sampled on a rising edge; the sweep runs with no
// back-pressure and done stays high until the next start or reset.
module truth_table_sweeper #(
   parameter int N_IN   = 3,
   parameter int SETTLE = 1,
   parameter int GRAY   = 0
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [2**N_IN-1:0]   expected,
   input  logic                 dut_out,
   output logic [N_IN-1:0]      stim,
   output logic                 busy,
   output logic                 done,
   output logic                 pass,
   output logic [N_IN:0]        err_count,
   output logic                 first_err_valid,
   output logic [N_IN-1:0]      first_err_vec,
   output logic [2**N_IN-1:0]   captured,
   output logic [1:0]           fsm_state
);

   localparam int NV = 2**N_IN;
   localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
   localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t state, next_state;

   logic [NV-1:0]   exp_q;
   logic [N_IN-1:0] idx;
   logic [CW-1:0]   settle_cnt;

   logic            start_sweep;
   logic            sample;
   logic            last_vec;
   logic            mismatch;
   logic [N_IN:0]   err_next;
   logic [N_IN-1:0] idx_next;

   // Sweep order: plain binary, or reflected Gray so consecutive vectors
   // differ in exactly one input bit.
   function automatic logic [N_IN-1:0] code(input logic [N_IN-1:0] i);
      if (GRAY != 0) return i ^ (i >> 1);
      else           return i;
   endfunction

   assign start_sweep = start && (state != RUN);
   assign sample      = (state == RUN) && (settle_cnt == SETTLE_LAST);
   assign last_vec    = (idx == {N_IN{1'b1}});
   // Expected table is indexed by the applied vector, not by sweep position.
   assign mismatch    = (dut_out != exp_q[stim]);
   assign err_next    = err_count + {{N_IN{1'b0}}, mismatch};
   assign idx_next    = idx + {{(N_IN-1){1'b0}}, 1'b1};

   assign busy      = (state == RUN);
   assign done      = (state == DONE);
   assign fsm_state = state;

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= next_state;
   end

   // Next-state logic
   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (start) next_state = RUN;
         RUN:     if (sample && last_vec) next_state = DONE;
         DONE:    if (start) next_state = RUN;
         default: next_state = IDLE;
      endcase
   end

   // Datapath: stimulus generation, capture and error bookkeeping
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         exp_q           <= '0;
         idx             <= '0;
         settle_cnt      <= '0;
         stim            <= '0;
         pass            <= 1'b0;
         err_count       <= '0;
         first_err_valid <= 1'b0;
         first_err_vec   <= '0;
         captured        <= '0;
      end else if (start_sweep) begin
         exp_q           <= expected;
         idx             <= '0;
         settle_cnt      <= '0;
         stim            <= '0;
         pass            <= 1'b0;
         err_count       <= '0;
         first_err_valid <= 1'b0;
         first_err_vec   <= '0;
         captured        <= '0;
      end else if (state == RUN) begin
         if (!sample) begin
            settle_cnt <= settle_cnt + CW'(1);
         end else begin
            captured[stim] <= dut_out;
            err_count      <= err_next;
            if (mismatch && !first_err_valid) begin
               first_err_valid <= 1'b1;
               first_err_vec   <= stim;
            end
            if (last_vec) begin
               // Includes a mismatch on this final sample.
               pass <= (err_next == '0);
            end else begin
               idx        <= idx_next;
               stim       <= code(idx_next);
               settle_cnt <= '0;
            end
         end
      end
   end

endmodule
